jk_bank_sequencer: RTL and testbench
====================================

Name: jk_bank_sequencer

Overview:
Command-driven controller that sequences a bank of WIDTH JK flip-flops. It generates the J/K excitation for each operation and holds the resulting register state: load, multi-step count up, multi-step count down, and clear. Upstream logic issues commands over a valid/ready handshake and sees a one-cycle done pulse when each command finishes. The JK bank is internal, and its Q outputs are exported alongside the live J/K drive for observation.

Parameters:
WIDTH, 4, number of JK flip-flops in the bank; also the width of cmd_data and of the step counter.

Ports:
clock  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept a command (high only in IDLE and not in reset)
cmd_op  input  2  00 LOAD, 01 UP, 10 DOWN, 11 CLEAR
cmd_data  input  WIDTH  LOAD: value to load; UP/DOWN: step count; CLEAR: ignored
j_out  output  WIDTH  current J excitation applied to the bank
k_out  output  WIDTH  current K excitation applied to the bank
q  output  WIDTH  JK bank state
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse when a command completes

Behaviour:
- Clock and reset:
  - One clock. Reset is synchronous and active-high.
  - While reset is sampled high at a rising edge: q=0, state=IDLE, step counter=0, latched op=LOAD, latched data=0.
  - While reset is high: cmd_ready=0, done=0, busy=0, j_out=k_out=0.
  - Reset sampled high during RUN or DONE aborts the command. No done pulse is produced, and q clears on that same edge.
- JK rule per bit at each rising edge (not in reset):
  - J=0, K=0: hold.
  - J=0, K=1: clear to 0.
  - J=1, K=0: set to 1.
  - J=1, K=1: toggle.
- Acceptance:
  - A command is accepted at an edge where cmd_valid=1 and cmd_ready=1 (call this edge E0).
  - cmd_op and cmd_data are latched at E0.
  - cmd_valid while not ready is ignored; no queueing.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN at E0, except UP/DOWN with cmd_data=0, which goes IDLE -> DONE at E0 with q unchanged.
  - RUN, op LOAD or CLEAR: exactly one cycle, then RUN -> DONE.
  - RUN, op UP or DOWN: one cycle per step. The step counter is loaded with cmd_data at E0 and decremented each RUN edge. RUN -> DONE on the edge where the counter goes 1 -> 0.
  - DONE -> IDLE unconditionally after one cycle.
- Outputs by state:
  - done=1 exactly while in DONE.
  - cmd_ready=1 exactly while in IDLE (and not in reset). This gives a minimum of one idle cycle between commands.
- Excitation (combinational from state, latched op/data and q):
  - IDLE and DONE: j_out=k_out=0.
  - RUN LOAD: j_out=data, k_out=~data.
  - RUN CLEAR: j_out=0, k_out=all ones.
  - RUN UP: j_out[i]=k_out[i]=AND(q[i-1:0]); bit 0 = 1.
  - RUN DOWN: j_out[i]=k_out[i]=AND(~q[i-1:0]); bit 0 = 1.
- Arithmetic and latency:
  - Counting is modulo 2^WIDTH. UP wraps all-ones -> 0; DOWN wraps 0 -> all-ones.
  - Latency from E0 to the done cycle: LOAD/CLEAR 2 edges; UP/DOWN with n>0 steps n+1 edges; n=0 1 edge.
  - q is final when done is high.

Test Plan:
- Reset (WIDTH=4): hold reset 2 cycles -> q=0, cmd_ready=0 during reset, then cmd_ready=1, busy=0, done=0.
- LOAD 4'hA -> during RUN j_out=1010 and k_out=0101; q=4'hA when done=1; done high exactly 1 cycle; cmd_ready returns next cycle.
- From q=4'hE, UP with cmd_data=3 -> q steps E, F, 0, 1; done in the cycle after the 3rd RUN edge; final q=4'h1.
- From q=4'h1, DOWN 2 -> q steps 0, F; final q=4'hF. Then UP 0 -> done one cycle after acceptance, q stays 4'hF, j_out=k_out=0 throughout.
- Hold cmd_valid with CLEAR during an UP 5 in progress -> CLEAR ignored while busy, UP completes, then CLEAR accepted in IDLE -> q=0.
- Assert reset at the 2nd RUN cycle of UP 6 from q=3 -> q=0 after the reset edge, no done pulse, state IDLE, cmd_ready=1 once reset deasserts.

Source files
------------

// File: rtl/jk_bank_sequencer.sv
// jk_bank_sequencer: command-driven controller for a bank of WIDTH JK flip-flops.
// Accepts LOAD / UP / DOWN / CLEAR over valid/ready, drives the J/K excitation
// that performs each operation, and pulses done for one cycle on completion.
module jk_bank_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_UP    = 2'b01;
    localparam logic [1:0] OP_DOWN  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_cnt;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;
    logic             w_carry;
    logic             w_ready;
    logic             w_accept;
    logic             w_zero_step;

    assign w_accept    = cmd_valid && w_ready;
    assign w_zero_step = ((cmd_op == OP_UP) || (cmd_op == OP_DOWN)) && (cmd_data == '0);

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and handshake/status outputs.
    always_comb begin
        w_next_state = r_state;
        w_ready      = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = !reset;
                if (w_accept) begin
                    // A zero-step count has nothing to do and completes immediately.
                    w_next_state = w_zero_step ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                busy = !reset;
                if ((r_op == OP_LOAD) || (r_op == OP_CLEAR)) begin
                    w_next_state = S_DONE;
                end else if (r_cnt == CNT_ONE) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                busy         = !reset;
                done         = !reset;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // J/K excitation: counting uses the classic ripple-enable form where a bit
    // toggles when every lower bit is 1 (up) or 0 (down).
    always_comb begin
        w_j     = '0;
        w_k     = '0;
        w_carry = 1'b1;
        if (r_state == S_RUN) begin
            case (r_op)
                OP_LOAD: begin
                    w_j = r_data;
                    w_k = ~r_data;
                end
                OP_CLEAR: begin
                    w_k = '1;
                end
                OP_UP: begin
                    for (int i = 0; i < WIDTH; i++) begin
                        w_j[i]  = w_carry;
                        w_k[i]  = w_carry;
                        w_carry = w_carry & r_q[i];
                    end
                end
                default: begin
                    for (int i = 0; i < WIDTH; i++) begin
                        w_j[i]  = w_carry;
                        w_k[i]  = w_carry;
                        w_carry = w_carry & ~r_q[i];
                    end
                end
            endcase
        end
    end

    // JK bank, command latch and step counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_q    <= '0;
            r_cnt  <= '0;
            r_op   <= OP_LOAD;
            r_data <= '0;
        end else begin
            r_q <= (w_j & ~r_q) | (~w_k & r_q);
            if (w_accept) begin
                r_op   <= cmd_op;
                r_data <= cmd_data;
                r_cnt  <= cmd_data;
            end else if ((r_state == S_RUN) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CNT_ONE;
            end
        end
    end

    assign cmd_ready = w_ready;
    assign q         = r_q;
    assign j_out     = reset ? '0 : w_j;
    assign k_out     = reset ? '0 : w_k;

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Testbench for jk_bank_sequencer: table of commands with hand-computed
// results, plus hand-written sequences for busy-hold and reset-abort cases.
module tb_jk_bank_sequencer;

    logic       clock;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_data;
    logic [3:0] j_out;
    logic [3:0] k_out;
    logic [3:0] q;
    logic       busy;
    logic       done;

    int n_cmp;
    int n_fail;

    typedef struct {
        logic [1:0] op;
        logic [3:0] data;
        logic [3:0] exp_j;   // excitation in the first cycle after acceptance
        logic [3:0] exp_k;
        logic [3:0] exp_q;   // q when done is high
        int         exp_lat; // edges from acceptance to the done cycle
    } vec_t;

    vec_t tbl[12];

    jk_bank_sequencer #(.WIDTH(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .j_out     (j_out),
        .k_out     (k_out),
        .q         (q),
        .busy      (busy),
        .done      (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!cmd_ready && n < 20) begin
            tick();
            n++;
        end
        check("wait_ready", int'(cmd_ready), 1);
    endtask

    initial begin
        logic [3:0] start_q;
        logic [3:0] e_q;
        int         lat;

        n_cmp     = 0;
        n_fail    = 0;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_data  = 4'h0;

        tbl[0]  = '{2'b00, 4'hA, 4'hA, 4'h5, 4'hA, 2};  // LOAD A
        tbl[1]  = '{2'b00, 4'hE, 4'hE, 4'h1, 4'hE, 2};  // LOAD E
        tbl[2]  = '{2'b01, 4'h3, 4'h1, 4'h1, 4'h1, 4};  // UP 3: E,F,0,1
        tbl[3]  = '{2'b10, 4'h2, 4'h1, 4'h1, 4'hF, 3};  // DOWN 2: 1,0,F
        tbl[4]  = '{2'b01, 4'h0, 4'h0, 4'h0, 4'hF, 1};  // UP 0
        tbl[5]  = '{2'b11, 4'h7, 4'h0, 4'hF, 4'h0, 2};  // CLEAR
        tbl[6]  = '{2'b10, 4'h1, 4'hF, 4'hF, 4'hF, 2};  // DOWN 1 from 0 wraps
        tbl[7]  = '{2'b01, 4'h1, 4'hF, 4'hF, 4'h0, 2};  // UP 1 from F wraps
        tbl[8]  = '{2'b00, 4'h5, 4'h5, 4'hA, 4'h5, 2};  // LOAD 5
        tbl[9]  = '{2'b10, 4'hF, 4'h1, 4'h1, 4'h6, 16}; // DOWN 15: 5-15 = 6
        tbl[10] = '{2'b01, 4'hF, 4'h1, 4'h1, 4'h5, 16}; // UP 15: 6+15 = 5
        tbl[11] = '{2'b10, 4'h0, 4'h0, 4'h0, 4'h5, 1};  // DOWN 0

        // Reset held for two cycles
        tick();
        tick();
        check("rst_q", int'(q), 0);
        check("rst_ready", int'(cmd_ready), 0);
        check("rst_done", int'(done), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_j", int'(j_out), 0);
        check("rst_k", int'(k_out), 0);
        reset = 1'b0;
        #1;
        check("post_rst_ready", int'(cmd_ready), 1);
        check("post_rst_busy", int'(busy), 0);
        check("post_rst_done", int'(done), 0);

        // Table-driven command sequence
        for (int v = 0; v < 12; v++) begin
            wait_ready();
            start_q   = q;
            cmd_op    = tbl[v].op;
            cmd_data  = tbl[v].data;
            cmd_valid = 1'b1;
            tick();
            cmd_valid = 1'b0;
            lat = 1;
            check($sformatf("v%0d_j", v), int'(j_out), int'(tbl[v].exp_j));
            check($sformatf("v%0d_k", v), int'(k_out), int'(tbl[v].exp_k));
            while (!done && lat < 40) begin
                if (tbl[v].op == 2'b01) begin
                    e_q = start_q + 4'(lat - 1);
                    check($sformatf("v%0d_q_step", v), int'(q), int'(e_q));
                end else if (tbl[v].op == 2'b10) begin
                    e_q = start_q - 4'(lat - 1);
                    check($sformatf("v%0d_q_step", v), int'(q), int'(e_q));
                end
                check($sformatf("v%0d_ready_busy", v), int'(cmd_ready), 0);
                tick();
                lat++;
            end
            check($sformatf("v%0d_latency", v), lat, tbl[v].exp_lat);
            check($sformatf("v%0d_q", v), int'(q), int'(tbl[v].exp_q));
            check($sformatf("v%0d_busy_done", v), int'(busy), 1);
            check($sformatf("v%0d_jk_done", v), int'({j_out, k_out}), 0);
            tick();
            check($sformatf("v%0d_done_width", v), int'(done), 0);
            check($sformatf("v%0d_ready_after", v), int'(cmd_ready), 1);
            check($sformatf("v%0d_busy_after", v), int'(busy), 0);
        end

        // CLEAR held on cmd_valid while UP 5 (from 5) is in progress
        wait_ready();
        cmd_op    = 2'b01;
        cmd_data  = 4'h5;
        cmd_valid = 1'b1;
        tick();
        cmd_op   = 2'b11;
        cmd_data = 4'h0;
        lat = 1;
        while (!done && lat < 40) begin
            check("hold_ready_low", int'(cmd_ready), 0);
            check("hold_busy", int'(busy), 1);
            tick();
            lat++;
        end
        check("hold_up_latency", lat, 6);
        check("hold_up_q", int'(q), 4'hA);
        tick();
        check("hold_idle_ready", int'(cmd_ready), 1);
        check("hold_idle_q", int'(q), 4'hA);
        tick();
        cmd_valid = 1'b0;
        check("hold_clear_busy", int'(busy), 1);
        check("hold_clear_k", int'(k_out), 4'hF);
        check("hold_clear_j", int'(j_out), 0);
        tick();
        check("hold_clear_done", int'(done), 1);
        check("hold_clear_q", int'(q), 0);
        tick();

        // Reset in the 2nd RUN cycle of UP 6 from q=3
        wait_ready();
        cmd_op    = 2'b00;
        cmd_data  = 4'h3;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        check("abort_load_q", int'(q), 3);
        tick();
        wait_ready();
        cmd_op    = 2'b01;
        cmd_data  = 4'h6;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("abort_run1_busy", int'(busy), 1);
        tick();
        check("abort_run2_q", int'(q), 4);
        reset = 1'b1;
        #1;
        check("abort_rst_jk", int'({j_out, k_out}), 0);
        check("abort_rst_busy", int'(busy), 0);
        check("abort_rst_ready", int'(cmd_ready), 0);
        tick();
        check("abort_q", int'(q), 0);
        check("abort_done", int'(done), 0);
        reset = 1'b0;
        #1;
        check("abort_ready", int'(cmd_ready), 1);
        check("abort_busy", int'(busy), 0);
        for (int c = 0; c < 4; c++) begin
            tick();
            check("abort_no_done", int'(done), 0);
            check("abort_q_hold", int'(q), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
